// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared constants, output-register state type and a one-hot
//               to index helper for the 4:1 stream merger.
//               Optional packet lock: STREAM_MUX_LOCK_EN (see stream_mux4x1).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Output register occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index of the set bit of a one-hot vector (0 when the vector is zero)
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Purely combinational 4-way round-robin arbiter. The search
//               starts at i_prio_ptr and wraps; the first requester found
//               gets a one-hot grant. i_enable=0 forces the grant to zero.
//               Pointer and lock state live in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import stream_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_prio_ptr,
  input  logic              i_enable,
  output logic [NUM_CH-1:0] o_grant
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  // Scan requesters in rotating order from the priority pointer
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = i_prio_ptr + SEL_W'(k);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
    if (!i_enable) begin
      o_grant = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux4x1.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux4x1
// Description : Four-input, one-output stream merger with round-robin
//               arbitration and a registered output stage. Each output beat
//               carries the index of its source channel in out_sel.
//               Define STREAM_MUX_LOCK_EN to hold the grant on one channel
//               from the first beat of a packet until its in_last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux4x1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_last
);

  state_t            r_state;
  state_t            w_state_next;
  logic [SEL_W-1:0]  r_prio_ptr;
  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_sel;
  logic              r_last;

  logic              w_can_take;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_idx;
  logic [WIDTH-1:0]  w_data_mux;
  logic              w_last_mux;

  // The register can take a new beat when empty or when it drains this cycle
  assign w_can_take = (r_state == EMPTY) || out_ready;

`ifdef STREAM_MUX_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_ch;

  // While locked, only the owning channel may request
  always_comb begin
    w_req = in_valid;
    if (r_lock) begin
      w_req = in_valid & (4'b0001 << r_lock_ch);
    end
  end

  // Lock on a non-final beat, release on the final beat of the owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_xfer) begin
      r_lock    <= ~w_last_mux;
      r_lock_ch <= w_idx;
    end
  end
`else
  assign w_req = in_valid;
`endif

  rr_arbiter4 u_arb (
    .i_req      (w_req),
    .i_prio_ptr (r_prio_ptr),
    .i_enable   (w_can_take & rst_n),
    .o_grant    (w_grant)
  );

  // Grant is a subset of in_valid, so any ready bit is a transfer
  assign in_ready = w_grant;
  assign w_xfer   = |w_grant;
  assign w_idx    = onehot_to_idx(w_grant);

  // Select payload and marker of the granted channel
  always_comb begin
    w_data_mux = in_data0;
    case (w_idx)
      2'd0:    w_data_mux = in_data0;
      2'd1:    w_data_mux = in_data1;
      2'd2:    w_data_mux = in_data2;
      default: w_data_mux = in_data3;
    endcase
    w_last_mux = in_last[w_idx];
  end

  // Output register occupancy: a transfer always fills, a drain empties
  always_comb begin
    w_state_next = r_state;
    if (w_xfer) begin
      w_state_next = FULL;
    end else if ((r_state == FULL) && out_ready) begin
      w_state_next = EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload fields load only on a transfer and otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
      r_last <= 1'b0;
    end else if (w_xfer) begin
      r_data <= w_data_mux;
      r_sel  <= w_idx;
      r_last <= w_last_mux;
    end
  end

  // Priority moves just past the winner; the 2-bit add wraps 3 to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio_ptr <= '0;
    end else if (w_xfer) begin
      r_prio_ptr <= w_idx + 2'd1;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux4x1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stream_mux4x1
// Description : Self-checking bench for stream_mux4x1 with directed
//               scenarios and a randomized run against a behavioural model.
//               Expectations follow STREAM_MUX_LOCK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] in_last;
  logic [7:0] p_data [4];
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_last;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic       m_full;
  logic [7:0] m_data;
  int         m_sel;
  logic       m_last;
  int         m_ptr;
  logic       m_lock;
  int         m_lock_ch;

  assign in_data0 = p_data[0];
  assign in_data1 = p_data[1];
  assign in_data2 = p_data[2];
  assign in_data3 = p_data[3];

  stream_mux4x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic model_reset;
    m_full = 1'b0; m_data = 8'h00; m_sel = 0; m_last = 1'b0;
    m_ptr = 0; m_lock = 1'b0; m_lock_ch = 0;
  endtask

  // Which channel the rules accept this cycle (one-hot, or zero)
  function automatic logic [3:0] model_ready(input logic [3:0] vld, input logic ordy, input logic rn);
    logic [3:0] r;
    r = 4'b0000;
    if (rn && (!m_full || ordy)) begin
`ifdef STREAM_MUX_LOCK_EN
      if (m_lock) begin
        if (vld[m_lock_ch]) r[m_lock_ch] = 1'b1;
      end else
`endif
      begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (vld[c] && r == 4'b0000) r[c] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Advance the model across one clock edge with the current inputs
  task automatic model_edge(input logic [3:0] vld, input logic ordy, input logic rn, output logic [3:0] acc);
    acc = model_ready(vld, ordy, rn);
    if (!rn) begin
      model_reset();
    end else if (acc != 4'b0000) begin
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) begin
          m_data = p_data[c]; m_sel = c; m_last = in_last[c];
          m_full = 1'b1; m_ptr = (c + 1) % 4;
          m_lock = ~in_last[c]; m_lock_ch = c;
        end
      end
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) p_data[c] = 8'h55;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    rst_n = 1'b1; in_valid = 4'b0000;
  endtask

  task automatic test_single_beat;
    do_reset();
    in_valid = 4'b0100; p_data[2] = 8'hA5; in_last = 4'b0100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    in_valid = 4'b0000;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    checks++; if (out_sel !== 2'd2) begin failures++; $display("FAIL single_out_sel got=%0d exp=2", out_sel); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL single_out_last got=%b exp=1", out_last); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_hold_data got=%h exp=a5", out_data); end
  endtask

  task automatic test_fairness;
    do_reset();
    for (int c = 0; c < 4; c++) p_data[c] = 8'h10 + 8'(c);
    in_last = 4'b1111; in_valid = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fair_valid[%0d] got=%b exp=1", n, out_valid); end
      checks++; if (out_sel !== 2'(n % 4)) begin failures++; $display("FAIL fair_sel[%0d] got=%0d exp=%0d", n, out_sel, n % 4); end
      checks++; if (out_data !== 8'h10 + 8'(n % 4)) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", n, out_data, 8'h10 + 8'(n % 4)); end
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_backpressure;
    do_reset();
    in_valid = 4'b0001; p_data[0] = 8'h11; in_last = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 4'b0110; p_data[1] = 8'h22; p_data[2] = 8'h33; out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", n, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd0) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/11/0", n, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_sel !== 2'd1) begin
      failures++; $display("FAIL bp_release_beat got=%b/%h/%0d exp=1/22/1", out_valid, out_data, out_sel);
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_lock;
    int seq_exp [5];
    int beat;
    logic [3:0] acc;
`ifdef STREAM_MUX_LOCK_EN
    seq_exp = '{1, 1, 1, 2, 0};
`else
    seq_exp = '{1, 2, 0, 1, 1};
`endif
    do_reset();
    beat = 0; out_ready = 1'b1;
    p_data[1] = 8'hB0; in_last = 4'b0000; in_valid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sel !== 2'(seq_exp[n])) begin
        failures++; $display("FAIL lock_seq[%0d] got=%b/%0d exp=1/%0d", n, out_valid, out_sel, seq_exp[n]);
      end
      if (n == 0) begin
        in_valid[0] = 1'b1; p_data[0] = 8'hC0; in_last[0] = 1'b1;
        in_valid[2] = 1'b1; p_data[2] = 8'hD0; in_last[2] = 1'b1;
      end
      if (acc[1]) begin
        beat++;
        if (beat < 3) begin p_data[1] = 8'hB0 + 8'(beat); in_last[1] = (beat == 2); end
        else in_valid[1] = 1'b0;
      end
      if (acc[0]) in_valid[0] = 1'b0;
      if (acc[2]) in_valid[2] = 1'b0;
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_mid_reset;
    do_reset();
    in_valid = 4'b0010; p_data[1] = 8'h77; in_last = 4'b0000; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_fill got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_dropped got=%b exp=0", out_valid); end
    rst_n = 1'b1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) p_data[c] = 8'hE0 + 8'(c);
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL midrst_first_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hE0) begin
      failures++; $display("FAIL midrst_first_beat got=%b/%0d/%h exp=1/0/e0", out_valid, out_sel, out_data);
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_random;
    logic [3:0] exp_rdy;
    logic [3:0] acc;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom % 4) != 0;
      rst_n = ($urandom % 80) != 0;
      #1;
      exp_rdy = model_ready(in_valid, out_ready, rst_n);
      checks++; if (in_ready !== exp_rdy || (in_ready & ~in_valid) !== 4'b0000) begin
        failures++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", n, in_ready, exp_rdy);
      end
      @(posedge clk); #1;
      model_edge(in_valid, out_ready, rst_n, acc);
      checks++; if (out_valid !== m_full || out_data !== m_data || out_sel !== 2'(m_sel) || out_last !== m_last) begin
        failures++; $display("FAIL rand_out[%0d] got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", n,
          out_valid, out_data, out_sel, out_last, m_full, m_data, m_sel, m_last);
      end
      for (int c = 0; c < 4; c++) begin
        if (acc[c] || (!in_valid[c] && ($urandom % 3) == 0)) begin
          in_valid[c] = acc[c] ? 1'($urandom % 2) : 1'b1;
          p_data[c]   = 8'($urandom);
          in_last[c]  = ($urandom % 3) == 0;
        end
      end
    end
    rst_n = 1'b1; in_valid = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) p_data[c] = 8'h00;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_beat();
    test_fairness();
    test_backpressure();
    test_lock();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
